fft_frame_buffer: RTL and testbench

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

---
 rtl/fft_frame_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_fft_frame_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer
// Ping-pong frame buffer between a sample-rate producer (low-pass filter) and
// a frame-oriented consumer (FFT). Two banks of N_FRAME words are filled and
// drained alternately. Samples are passed through bit-exact and in arrival
// order, and y_last marks the final word of every frame.
//
// Write side: x_ready is a pure decode of registered state (the full flag of
// the current write bank). It has no path from y_ready.
//
// Read side: a two-state FSM (IDLE / STREAM) with registered y_valid, y_data
// and y_last. When a frame ends and the other bank is full, word 0 of that
// bank is loaded directly. This includes the case where the other bank is
// being completed on the same edge, so continuous traffic never shows a
// bubble on y.

module fft_frame_buffer #(
  parameter int W       = 32,
  parameter int N_FRAME = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data,
  output logic         y_last
);

  localparam int IDX_W = (N_FRAME > 1) ? $clog2(N_FRAME) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_FRAME - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = {IDX_W{1'b0}};
  // y_last value when word 0 of a frame is loaded (only 1 for 1-word frames)
  localparam logic Y_LAST_FIRST = (N_FRAME == 1) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Frame storage; deliberately not reset, the full flags qualify contents
  logic [W-1:0]     mem_q [0:1][0:N_FRAME-1];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  state_t           state_q, state_d;
  logic             y_valid_q, y_valid_d;
  logic [W-1:0]     y_data_q, y_data_d;
  logic             y_last_q, y_last_d;

  logic             x_fire_s;
  logic             y_fire_s;
  logic             set_full_s;
  logic             clr_full_s;
  logic             other_full_s;
  logic [IDX_W-1:0] rd_idx_next_s;

  assign x_ready       = ~full_q[wr_bank_q];
  assign x_fire_s      = x_valid & ~full_q[wr_bank_q];
  assign y_fire_s      = y_valid_q & y_ready;
  assign rd_idx_next_s = rd_idx_q + IDX_W'(1);

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;

  // The other bank counts as full if already flagged or completed on this edge
  assign other_full_s = full_q[~rd_bank_q] | (set_full_s & (wr_bank_q != rd_bank_q));

  // Sample storage: write the accepted sample at the current write slot
  always_ff @(posedge clk) begin
    if (x_fire_s) begin
      mem_q[wr_bank_q][wr_idx_q] <= x_data;
    end
  end

  // Write pointer advance: index wraps at frame end and the bank toggles
  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    set_full_s = 1'b0;
    if (x_fire_s) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d   = FIRST_IDX;
        wr_bank_d  = ~wr_bank_q;
        set_full_s = 1'b1;
      end else begin
        wr_idx_d   = wr_idx_q + IDX_W'(1);
      end
    end else begin
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
    end
  end

  // Read FSM next-state: leave IDLE on a full bank, return when nothing queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (y_fire_s && y_last_q && !other_full_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read FSM outputs: load words, advance the read pointer, release banks
  always_comb begin
    y_valid_d  = y_valid_q;
    y_data_d   = y_data_q;
    y_last_d   = y_last_q;
    rd_idx_d   = rd_idx_q;
    rd_bank_d  = rd_bank_q;
    clr_full_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          y_valid_d = 1'b1;
          y_data_d  = mem_q[rd_bank_q][FIRST_IDX];
          y_last_d  = Y_LAST_FIRST;
        end else begin
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (y_fire_s) begin
          if (y_last_q) begin
            clr_full_s = 1'b1;
            rd_idx_d   = FIRST_IDX;
            rd_bank_d  = ~rd_bank_q;
            if (other_full_s) begin
              y_valid_d = 1'b1;
              y_data_d  = mem_q[~rd_bank_q][FIRST_IDX];
              y_last_d  = Y_LAST_FIRST;
            end else begin
              y_valid_d = 1'b0;
              y_last_d  = 1'b0;
            end
          end else begin
            rd_idx_d  = rd_idx_next_s;
            y_valid_d = 1'b1;
            y_data_d  = mem_q[rd_bank_q][rd_idx_next_s];
            y_last_d  = (rd_idx_next_s == LAST_IDX) ? 1'b1 : 1'b0;
          end
        end else begin
          y_valid_d = y_valid_q;
          y_data_d  = y_data_q;
          y_last_d  = y_last_q;
        end
      end
      default: begin
        y_valid_d = 1'b0;
        y_last_d  = 1'b0;
      end
    endcase
  end

  // Full flags: writer sets its bank, reader clears its bank, both may coincide
  always_comb begin
    full_d = full_q;
    if (set_full_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d = full_q;
    end
    if (clr_full_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= FIRST_IDX;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= FIRST_IDX;
      state_q   <= ST_IDLE;
      y_valid_q <= 1'b0;
      y_data_q  <= {W{1'b0}};
      y_last_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      state_q   <= state_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer (W=32, N_FRAME=4).
// A negedge monitor pushes every accepted x sample into an expected-output
// queue. The model is simple: the output stream equals the input stream, and
// y_last is set on every 4th sample since reset. The same monitor pops the
// queue on every y transfer and compares. Directed sequences add checks for
// reset values, latency, gapless streaming, backpressure, stall stability and
// mid-frame reset.

module tb_fft_frame_buffer;

  localparam int W  = 32;
  localparam int NF = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_data;
  logic         y_last;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t         sb_q[$];
  int           wcount;
  int           errors = 0;
  int           checks = 0;
  logic         hold_r = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         hold_l = 1'b0;
  logic         rand_done;

  fft_frame_buffer #(.W(W), .N_FRAME(NF)) dut (
    .clk    (clk),
    .reset  (reset),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data (x_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_data (y_data),
    .y_last (y_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: inputs are stable from negedge to the next posedge
  always @(negedge clk) begin
    if (reset) begin
      hold_r <= 1'b0;
    end else begin
      if (x_valid && x_ready) begin
        sb_q.push_back({x_data, ((wcount % NF) == NF - 1) ? 1'b1 : 1'b0});
        wcount <= wcount + 1;
      end
      if (hold_r) begin
        check("stall_valid", y_valid, 1);
        check("stall_data", y_data, hold_d);
        check("stall_last", y_last, hold_l);
      end
      if (y_valid && y_ready) begin
        if (sb_q.size() == 0) begin
          check("y_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("y_data", y_data, e.d);
          check("y_last", y_last, e.l);
        end
      end
      hold_r <= y_valid && !y_ready;
      hold_d <= y_data;
      hold_l <= y_last;
    end
  end

  // Offer one sample and hold it until accepted (bounded)
  task automatic send(input logic [W-1:0] d);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    x_valid = 1'b1;
    x_data  = d;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = x_ready;
      @(posedge clk);
      #1;
      n++;
    end
    x_valid = 1'b0;
    if (!ok) check("x_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    int n;
    reset   = 1'b1;
    x_valid = 1'b0;
    x_data  = '0;
    y_ready = 1'b0;
    wcount  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_valid", y_valid, 0);
    check("rst_y_last", y_last, 0);
    check("rst_y_data", y_data, 0);
    check("rst_x_ready", x_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Stream: 1..4 back to back. y_valid is first seen after the edge that
    // follows acceptance of 4, so the first y transfer is on the second edge.
    y_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(W'(i));
    @(negedge clk);
    check("lat_not_yet", y_valid, 0);
    @(negedge clk);
    check("lat_first_valid", y_valid, 1);
    check("lat_first_data", y_data, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_gapless", y_valid, 1);
    end
    wait_drain();

    // Backpressure: 12 samples, y blocked; only 8 fit
    y_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(W'(i));
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_x_ready_low", x_ready, 0);
        check("bp_accepted", sb_q.size(), 8);
        check("bp_y_valid", y_valid, 1);
        @(posedge clk);
        #1;
        y_ready = 1'b1;
      end
    join
    wait_drain();

    // Stall: output held at value 2 for 5 cycles
    y_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(W'(i));
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold2_valid", y_valid, 1);
      check("hold2_data", y_data, 2);
    end
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    @(negedge clk);
    check("resume_pending", y_data, 2);
    @(negedge clk);
    check("resume_data", y_data, 3);
    wait_drain();

    // Ping-pong: 24 continuous samples, y must not idle once primed
    y_ready = 1'b1;
    bubbles = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) send(W'(200 + i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!y_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("pp_started", y_valid, 1);
        for (int i = 0; i < 24; i++) begin
          if (!y_valid) bubbles++;
          @(negedge clk);
        end
        check("pp_bubbles", bubbles, 0);
      end
    join
    wait_drain();

    // Reset mid-frame with one unread frame pending
    y_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(W'(50 + i));
    send(W'(60));
    send(W'(61));
    check("pre_rst_valid", y_valid, 1);
    reset = 1'b1;
    sb_q.delete();
    wcount = 0;
    #1;
    check("rst_now_y_valid", y_valid, 0);
    check("rst_now_x_ready", x_ready, 1);
    check("rst_now_y_last", y_last, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    y_ready = 1'b1;
    for (int i = 10; i <= 13; i++) send(W'(i));
    wait_drain();

    // Random traffic: 10k samples with random gaps and backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send($urandom);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          y_ready = ($urandom_range(0, 3) != 0);
        end
        y_ready = 1'b1;
      end
    join
    wait_drain();
    check("final_y_idle", y_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
